// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the CPU fetch/data ports, the arbiter and the unified memory.
// master = CPU and memory side, slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of fetch and data ports onto one fixed-latency memory; rvalid MEM_LATENCY+1 after grant.
// One transaction in flight; requesters hold req until their combinational grant, grants blocked while busy.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CntW = $clog2(MEM_LATENCY + 1);

  typedef enum logic {IDLE, WAIT} stateT;

  stateT                 state;
  logic                  ownerD;
  logic                  lastD;
  logic                  writeQ;
  logic                  busyQ;
  logic                  iRvalidQ;
  logic                  dRvalidQ;
  logic [CntW-1:0]       cnt;
  logic [DATA_WIDTH-1:0] iRdataQ;
  logic [DATA_WIDTH-1:0] dRdataQ;

  logic isIdle;
  logic grantI;
  logic grantD;

  if (MEM_LATENCY < 1) begin : gBadLatency
    $error("mem_port_arbiter: MEM_LATENCY must be at least 1");
  end

  // On a tie the port that was not served last wins.
  assign isIdle = rst_n && (state == IDLE);
  assign grantI = isIdle && bus.i_req && (!bus.d_req || lastD);
  assign grantD = isIdle && bus.d_req && (!bus.i_req || !lastD);

  assign bus.i_gnt     = grantI;
  assign bus.d_gnt     = grantD;
  assign bus.mem_en    = grantI || grantD;
  assign bus.mem_we    = grantD && bus.d_we;
  assign bus.mem_addr  = grantD ? bus.d_addr : (grantI ? bus.i_addr : '0);
  assign bus.mem_wdata = grantD ? bus.d_wdata : '0;

  assign bus.busy     = busyQ;
  assign bus.i_rvalid = iRvalidQ;
  assign bus.d_rvalid = dRvalidQ;
  assign bus.i_rdata  = iRdataQ;
  assign bus.d_rdata  = dRdataQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ownerD   <= 1'b0;
      lastD    <= 1'b1;
      writeQ   <= 1'b0;
      busyQ    <= 1'b0;
      iRvalidQ <= 1'b0;
      dRvalidQ <= 1'b0;
      cnt      <= '0;
      iRdataQ  <= '0;
      dRdataQ  <= '0;
    end else begin
      iRvalidQ <= 1'b0;
      dRvalidQ <= 1'b0;
      case (state)
        IDLE: begin
          if (grantI || grantD) begin
            state  <= WAIT;
            ownerD <= grantD;
            lastD  <= grantD;
            writeQ <= grantD && bus.d_we;
            busyQ  <= 1'b1;
            cnt    <= CntW'(MEM_LATENCY);
          end
        end
        WAIT: begin
          cnt <= cnt - CntW'(1);
          // Memory data is valid in the last counted cycle; writes only ack.
          if (cnt == CntW'(1)) begin
            state <= IDLE;
            busyQ <= 1'b0;
            if (ownerD) begin
              dRvalidQ <= 1'b1;
              if (!writeQ) begin
                dRdataQ <= bus.mem_rdata;
              end
            end else begin
              iRvalidQ <= 1'b1;
              iRdataQ  <= bus.mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(bus.i_gnt && bus.d_gnt));
  assert property (@(posedge clk) disable iff (!rst_n) busyQ |-> !bus.mem_en);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: latency-2 instance with a word-array memory model,
// latency-1 instance whose memory returns address+1.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if ifA ();
  mem_port_arbiter_if ifB ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA.slave)
  );
  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(ifB.slave)
  );

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] iExpQ[$];
  logic [31:0] dExpQ[$];
  logic [31:0] dExpB[$];

  // Memory model A: 32 words with fixed initial contents, two-cycle read pipe.
  logic [31:0] memA [32];
  logic [31:0] wrA = '0;
  logic [31:0] pipeA0 = '0;
  logic [31:0] pipeA1 = '0;
  logic [31:0] pipeB = '0;

  function automatic logic [31:0] initWord(input logic [4:0] idx);
    case (idx)
      5'd4:    initWord = 32'h2002_0005;
      5'd8:    initWord = 32'hA5A5_0008;
      5'd9:    initWord = 32'h5A5A_0009;
      5'd17:   initWord = 32'h1234_5678;
      default: initWord = {16'hC0DE, 11'd0, idx};
    endcase
  endfunction

  always @(posedge clk) begin
    if (ifA.mem_en) begin
      pipeA0 <= wrA[ifA.mem_addr[6:2]] ? memA[ifA.mem_addr[6:2]] : initWord(ifA.mem_addr[6:2]);
    end else begin
      pipeA0 <= 32'hBAD0_BAD0;
    end
    pipeA1 <= pipeA0;
    if (ifA.mem_en && ifA.mem_we) begin
      memA[ifA.mem_addr[6:2]] <= ifA.mem_wdata;
      wrA[ifA.mem_addr[6:2]]  <= 1'b1;
    end
    pipeB <= ifB.mem_en ? ifB.mem_addr + 32'd1 : 32'hBAD1_BAD1;
  end
  assign ifA.mem_rdata = pipeA1;
  assign ifB.mem_rdata = pipeB;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifA.i_req = 1'b1; ifA.i_addr = 32'h10; ifA.d_req = 1'b1; ifA.d_we = 1'b1;
    ifA.d_addr = 32'h40; ifA.d_wdata = 32'hFFFF_FFFF;
    ifB.i_req = 1'b1; ifB.i_addr = 32'h0; ifB.d_req = 1'b1; ifB.d_we = 1'b0;
    ifB.d_addr = 32'h0; ifB.d_wdata = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nChecks++;
    if ({ifA.i_gnt, ifA.d_gnt, ifA.mem_en, ifA.busy, ifA.i_rvalid, ifA.d_rvalid} !== 6'b0) begin
      nFails++;
      $display("FAIL reset_ctrl_A: got %b want 000000",
               {ifA.i_gnt, ifA.d_gnt, ifA.mem_en, ifA.busy, ifA.i_rvalid, ifA.d_rvalid});
    end
    nChecks++;
    if ({ifA.mem_we, ifA.mem_addr, ifA.mem_wdata} !== 65'b0) begin
      nFails++;
      $display("FAIL reset_mem_A: we=%b addr=%h wdata=%h want all 0", ifA.mem_we, ifA.mem_addr, ifA.mem_wdata);
    end
    nChecks++;
    if ({ifA.i_rdata, ifA.d_rdata} !== 64'b0) begin
      nFails++;
      $display("FAIL reset_rdata_A: got i=%h d=%h want 0", ifA.i_rdata, ifA.d_rdata);
    end
    nChecks++;
    if ({ifB.i_gnt, ifB.d_gnt, ifB.mem_en, ifB.busy, ifB.i_rvalid, ifB.d_rvalid} !== 6'b0) begin
      nFails++;
      $display("FAIL reset_ctrl_B: got %b want 000000",
               {ifB.i_gnt, ifB.d_gnt, ifB.mem_en, ifB.busy, ifB.i_rvalid, ifB.d_rvalid});
    end
    cyc();
    rst_n = 1'b1;
    ifA.i_req = 1'b0; ifA.d_req = 1'b0; ifA.d_we = 1'b0;
    ifB.i_req = 1'b0; ifB.d_req = 1'b0;
    @(negedge clk);
    nChecks++;
    if ({ifA.mem_en, ifA.mem_we, ifA.mem_addr, ifA.mem_wdata, ifA.busy} !== 67'b0) begin
      nFails++;
      $display("FAIL idle_mem_A: en=%b we=%b addr=%h wdata=%h busy=%b want all 0",
               ifA.mem_en, ifA.mem_we, ifA.mem_addr, ifA.mem_wdata, ifA.busy);
    end
  endtask

  task automatic test_single_fetch();
    logic [31:0] exp;
    cyc();
    ifA.i_req = 1'b1; ifA.i_addr = 32'h10;
    iExpQ.push_back(32'h2002_0005);
    @(negedge clk);
    nChecks++;
    if ({ifA.i_gnt, ifA.d_gnt, ifA.mem_en, ifA.mem_we} !== 4'b1010) begin
      nFails++;
      $display("FAIL fetch_issue: gnt_i/gnt_d/en/we got %b want 1010",
               {ifA.i_gnt, ifA.d_gnt, ifA.mem_en, ifA.mem_we});
    end
    nChecks++;
    if (ifA.mem_addr !== 32'h10) begin
      nFails++;
      $display("FAIL fetch_addr: got %h want 00000010", ifA.mem_addr);
    end
    for (int c = 1; c <= 4; c++) begin
      cyc();
      if (c == 1) ifA.i_req = 1'b0;
      @(negedge clk);
      nChecks++;
      if ({ifA.busy, ifA.i_rvalid} !== {(c <= 2), (c == 3)}) begin
        nFails++;
        $display("FAIL fetch_busy_rvalid c%0d: got %b want %b", c, {ifA.busy, ifA.i_rvalid}, {(c <= 2), (c == 3)});
      end
      if (ifA.i_rvalid) begin
        nChecks++;
        if (iExpQ.size() == 0) begin
          nFails++;
          $display("FAIL fetch_rdata: rvalid with nothing outstanding, data %h", ifA.i_rdata);
        end else begin
          exp = iExpQ.pop_front();
          if (ifA.i_rdata !== exp) begin
            nFails++;
            $display("FAIL fetch_rdata: got %h want %h", ifA.i_rdata, exp);
          end
        end
      end
    end
    nChecks++;
    if (ifA.i_rdata !== 32'h2002_0005) begin
      nFails++;
      $display("FAIL fetch_rdata_hold: got %h want 20020005", ifA.i_rdata);
    end
  endtask

  task automatic test_contention();
    logic [31:0] exp;
    logic expI, expD, expIR, expDR;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    ifA.i_req = 1'b1; ifA.i_addr = 32'h20;
    ifA.d_req = 1'b1; ifA.d_we = 1'b0; ifA.d_addr = 32'h24;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) cyc();
      if (c == 12) begin
        ifA.i_req = 1'b0; ifA.d_req = 1'b0;
      end
      expI  = (c % 3 == 0) && (c < 12) && ((c / 3) % 2 == 0);
      expD  = (c % 3 == 0) && (c < 12) && ((c / 3) % 2 == 1);
      expIR = (c >= 3) && (c % 3 == 0) && ((c / 3 - 1) % 2 == 0);
      expDR = (c >= 3) && (c % 3 == 0) && ((c / 3 - 1) % 2 == 1);
      if (expI) iExpQ.push_back(32'hA5A5_0008);
      if (expD) dExpQ.push_back(32'h5A5A_0009);
      @(negedge clk);
      nChecks++;
      if ({ifA.i_gnt, ifA.d_gnt} !== {expI, expD}) begin
        nFails++;
        $display("FAIL contention_gnt c%0d: got %b want %b", c, {ifA.i_gnt, ifA.d_gnt}, {expI, expD});
      end
      nChecks++;
      if ({ifA.i_rvalid, ifA.d_rvalid} !== {expIR, expDR}) begin
        nFails++;
        $display("FAIL contention_rvalid c%0d: got %b want %b", c, {ifA.i_rvalid, ifA.d_rvalid}, {expIR, expDR});
      end
      if (ifA.i_rvalid) begin
        nChecks++;
        if (iExpQ.size() == 0) begin
          nFails++;
          $display("FAIL contention_irdata c%0d: rvalid with nothing outstanding", c);
        end else begin
          exp = iExpQ.pop_front();
          if (ifA.i_rdata !== exp) begin
            nFails++;
            $display("FAIL contention_irdata c%0d: got %h want %h", c, ifA.i_rdata, exp);
          end
        end
      end
      if (ifA.d_rvalid) begin
        nChecks++;
        if (dExpQ.size() == 0) begin
          nFails++;
          $display("FAIL contention_drdata c%0d: rvalid with nothing outstanding", c);
        end else begin
          exp = dExpQ.pop_front();
          if (ifA.d_rdata !== exp) begin
            nFails++;
            $display("FAIL contention_drdata c%0d: got %h want %h", c, ifA.d_rdata, exp);
          end
        end
      end
    end
  endtask

  task automatic test_data_write();
    logic [31:0] exp;
    cyc();
    ifA.d_req = 1'b1; ifA.d_we = 1'b0; ifA.d_addr = 32'h44;
    dExpQ.push_back(32'h1234_5678);
    @(negedge clk);
    nChecks++;
    if ({ifA.i_gnt, ifA.d_gnt} !== 2'b01) begin
      nFails++;
      $display("FAIL write_preload_gnt: got %b want 01", {ifA.i_gnt, ifA.d_gnt});
    end
    for (int c = 1; c <= 9; c++) begin
      cyc();
      case (c)
        1: ifA.d_req = 1'b0;
        3: begin
          ifA.d_req = 1'b1; ifA.d_we = 1'b1; ifA.d_addr = 32'h40; ifA.d_wdata = 32'hDEAD_BEEF;
          dExpQ.push_back(32'h1234_5678);
        end
        4: begin ifA.d_req = 1'b0; ifA.d_we = 1'b0; ifA.d_wdata = 32'h0; end
        6: begin
          ifA.d_req = 1'b1; ifA.d_we = 1'b0; ifA.d_addr = 32'h40;
          dExpQ.push_back(32'hDEAD_BEEF);
        end
        7: ifA.d_req = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (c == 3) begin
        nChecks++;
        if ({ifA.d_gnt, ifA.mem_en, ifA.mem_we} !== 3'b111 || ifA.mem_addr !== 32'h40
            || ifA.mem_wdata !== 32'hDEAD_BEEF) begin
          nFails++;
          $display("FAIL write_issue: gnt/en/we=%b addr=%h wdata=%h want 111 00000040 deadbeef",
                   {ifA.d_gnt, ifA.mem_en, ifA.mem_we}, ifA.mem_addr, ifA.mem_wdata);
        end
      end
      nChecks++;
      if (ifA.d_rvalid !== (c == 3 || c == 6 || c == 9)) begin
        nFails++;
        $display("FAIL write_rvalid c%0d: got %b want %b", c, ifA.d_rvalid, (c == 3 || c == 6 || c == 9));
      end
      if (ifA.d_rvalid) begin
        nChecks++;
        if (dExpQ.size() == 0) begin
          nFails++;
          $display("FAIL write_rdata c%0d: rvalid with nothing outstanding", c);
        end else begin
          exp = dExpQ.pop_front();
          if (ifA.d_rdata !== exp) begin
            nFails++;
            $display("FAIL write_rdata c%0d: got %h want %h", c, ifA.d_rdata, exp);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    cyc();
    ifA.d_req = 1'b1; ifA.d_we = 1'b0; ifA.d_addr = 32'h44;
    @(negedge clk);
    nChecks++;
    if (ifA.d_gnt !== 1'b1) begin
      nFails++;
      $display("FAIL rstmid_issue: d_gnt got %b want 1", ifA.d_gnt);
    end
    for (int c = 1; c <= 10; c++) begin
      cyc();
      case (c)
        1: begin rst_n = 1'b0; ifA.i_req = 1'b1; ifA.i_addr = 32'h10; end
        4: begin rst_n = 1'b1; iExpQ.push_back(32'h2002_0005); end
        5: ifA.i_req = 1'b0;
        7: dExpQ.push_back(32'h1234_5678);
        8: ifA.d_req = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (c <= 3) begin
        nChecks++;
        if ({ifA.busy, ifA.i_gnt, ifA.d_gnt, ifA.mem_en} !== 4'b0) begin
          nFails++;
          $display("FAIL rstmid_hold c%0d: busy/gnt_i/gnt_d/en got %b want 0000",
                   c, {ifA.busy, ifA.i_gnt, ifA.d_gnt, ifA.mem_en});
        end
      end
      if (c == 4) begin
        nChecks++;
        if ({ifA.i_gnt, ifA.d_gnt} !== 2'b10) begin
          nFails++;
          $display("FAIL rstmid_first_gnt: got %b want 10", {ifA.i_gnt, ifA.d_gnt});
        end
      end
      nChecks++;
      if ({ifA.i_rvalid, ifA.d_rvalid} !== {(c == 7), (c == 10)}) begin
        nFails++;
        $display("FAIL rstmid_rvalid c%0d: got %b want %b", c, {ifA.i_rvalid, ifA.d_rvalid}, {(c == 7), (c == 10)});
      end
      if (ifA.i_rvalid && iExpQ.size() != 0) begin
        exp = iExpQ.pop_front();
        nChecks++;
        if (ifA.i_rdata !== exp) begin
          nFails++;
          $display("FAIL rstmid_irdata: got %h want %h", ifA.i_rdata, exp);
        end
      end
      if (ifA.d_rvalid && dExpQ.size() != 0) begin
        exp = dExpQ.pop_front();
        nChecks++;
        if (ifA.d_rdata !== exp) begin
          nFails++;
          $display("FAIL rstmid_drdata: got %h want %h", ifA.d_rdata, exp);
        end
      end
    end
    nChecks++;
    if (iExpQ.size() != 0 || dExpQ.size() != 0) begin
      nFails++;
      $display("FAIL scoreboard_drain: %0d fetch and %0d data results outstanding, want 0", iExpQ.size(), dExpQ.size());
    end
  endtask

  task automatic test_latency1();
    logic [31:0] exp;
    for (int c = 0; c <= 5; c++) begin
      cyc();
      case (c)
        0: begin ifB.d_req = 1'b1; ifB.d_we = 1'b0; ifB.d_addr = 32'h0; dExpB.push_back(32'h1); end
        1: ifB.d_req = 1'b0;
        2: begin ifB.d_req = 1'b1; ifB.d_addr = 32'h4; dExpB.push_back(32'h5); end
        3: ifB.d_req = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      nChecks++;
      if ({ifB.d_gnt, ifB.busy, ifB.d_rvalid} !== {(c == 0 || c == 2), (c == 1 || c == 3), (c == 2 || c == 4)}) begin
        nFails++;
        $display("FAIL lat1_ctrl c%0d: gnt/busy/rvalid got %b want %b", c, {ifB.d_gnt, ifB.busy, ifB.d_rvalid},
                 {(c == 0 || c == 2), (c == 1 || c == 3), (c == 2 || c == 4)});
      end
      if (ifB.d_rvalid) begin
        nChecks++;
        if (dExpB.size() == 0) begin
          nFails++;
          $display("FAIL lat1_rdata c%0d: rvalid with nothing outstanding", c);
        end else begin
          exp = dExpB.pop_front();
          if (ifB.d_rdata !== exp) begin
            nFails++;
            $display("FAIL lat1_rdata c%0d: got %h want %h", c, ifB.d_rdata, exp);
          end
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    test_reset();
    test_single_fetch();
    test_contention();
    test_data_write();
    test_reset_mid();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
